// File: rtl/fib_seq_ctrl_pkg.sv
// Shared types and defaults for the Fibonacci fill sequencer and the
// register file / RAM wrappers it drives.
package fib_seq_ctrl_pkg;

   localparam int unsigned DefAddrW = 6;
   localparam int unsigned DefDataW = 32;

   // ALU opcode for an unsigned wrapping add.
   localparam logic [4:0] AluOpAdd = 5'd1;

   typedef enum logic [2:0] {
      StIdle,
      StLoadRd,
      StLoadWr,
      StRdA,
      StRdB,
      StExec,
      StDone
   } fib_state_e;

endpackage

// File: rtl/fib_seq_ctrl.sv
// Fibonacci fill sequencer: copies seed words from RAM port B into the
// register file, then computes r[i] = r[i-2] + r[i-1] up to LAST_ADDR using
// the external ALU, writing each result to the register file and RAM port A.
module fib_seq_ctrl
   import fib_seq_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W     = DefAddrW,
   parameter int unsigned DATA_W     = DefDataW,
   parameter int unsigned SEED_CNT   = 2,
   parameter int unsigned LAST_ADDR  = 63,
   parameter logic [4:0]  ALU_OP_ADD = AluOpAdd
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              rf_we,
   output logic [ADDR_W-1:0] ram_addrb,
   input  logic [DATA_W-1:0] ram_doutb,
   output logic [ADDR_W-1:0] ram_addra,
   output logic [DATA_W-1:0] ram_dina,
   output logic              ram_wea,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [4:0]        alu_op,
   input  logic [DATA_W-1:0] alu_out
);

   localparam logic [ADDR_W-1:0] SeedLast = ADDR_W'(SEED_CNT - 1);
   localparam logic [ADDR_W-1:0] SeedCnt  = ADDR_W'(SEED_CNT);
   localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(LAST_ADDR);

   fib_state_e        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;

   // State, index and operand registers; reset drops any job in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
      end
   end

   // Next-state and Moore output decode; only write data passes through inputs.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      busy      = (state_q != StIdle);
      done      = 1'b0;
      rf_raddr  = '0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      rf_we     = 1'b0;
      ram_addrb = '0;
      ram_addra = '0;
      ram_dina  = '0;
      ram_wea   = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      alu_op    = '0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               idx_d   = '0;
               state_d = StLoadRd;
            end
         end
         StLoadRd: begin
            ram_addrb = idx_q;
            state_d   = StLoadWr;
         end
         StLoadWr: begin
            // RAM read data is valid now, one cycle after the address.
            rf_we    = 1'b1;
            rf_waddr = idx_q;
            rf_wdata = ram_doutb;
            if (idx_q == SeedLast) begin
               idx_d   = SeedCnt;
               state_d = StRdA;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = StLoadRd;
            end
         end
         StRdA: begin
            rf_raddr = idx_q - ADDR_W'(2);
            opa_d    = rf_rdata;
            state_d  = StRdB;
         end
         StRdB: begin
            rf_raddr = idx_q - ADDR_W'(1);
            opb_d    = rf_rdata;
            state_d  = StExec;
         end
         StExec: begin
            alu_a     = opa_q;
            alu_b     = opb_q;
            alu_op    = ALU_OP_ADD;
            rf_we     = 1'b1;
            rf_waddr  = idx_q;
            rf_wdata  = alu_out;
            ram_wea   = 1'b1;
            ram_addra = idx_q;
            ram_dina  = alu_out;
            // Compare before increment so idx never wraps at the top address.
            if (idx_q == LastIdx) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = StRdA;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl: behavioural register file, RAM and
// ALU models around a default instance and a short LAST_ADDR=5 instance.
module tb_fib_seq_ctrl;
   import fib_seq_ctrl_pkg::*;

   localparam int unsigned AW       = 6;
   localparam int unsigned DW       = 32;
   localparam int unsigned SEEDS    = 2;
   localparam int unsigned LAST     = 63;
   localparam int          DONE_CYC = 2 * SEEDS + 3 * (LAST - SEEDS + 1) + 1;

   logic clk, rst, start, start_s;

   // Default instance signals
   logic          busy, done, rf_we, ram_wea;
   logic [AW-1:0] rf_raddr, rf_waddr, ram_addrb, ram_addra;
   logic [DW-1:0] rf_rdata, rf_wdata, ram_doutb, ram_dina, alu_a, alu_b, alu_out;
   logic [4:0]    alu_op;

   // Short instance signals
   logic          busy_s, done_s, rf_we_s, ram_wea_s;
   logic [AW-1:0] rf_raddr_s, rf_waddr_s, ram_addrb_s, ram_addra_s;
   logic [DW-1:0] rf_rdata_s, rf_wdata_s, ram_doutb_s, ram_dina_s;
   logic [DW-1:0] alu_a_s, alu_b_s, alu_out_s;
   logic [4:0]    alu_op_s;

   // Seed loader into both RAM models
   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;

   logic [DW-1:0] rf_mem [64];
   logic [DW-1:0] ram_mem [64];
   logic [DW-1:0] rf_mem_s [64];
   logic [DW-1:0] ram_mem_s [64];

   logic [AW+DW-1:0] exp_q [$];
   int n_checks = 0;
   int n_errors = 0;

   logic outs_nz;
   assign outs_nz = |{busy, done, rf_we, ram_wea, rf_raddr, rf_waddr, rf_wdata, ram_addrb,
                      ram_addra, ram_dina, alu_a, alu_b, alu_op};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fib_seq_ctrl u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .rf_raddr  (rf_raddr),
      .rf_rdata  (rf_rdata),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .rf_we     (rf_we),
      .ram_addrb (ram_addrb),
      .ram_doutb (ram_doutb),
      .ram_addra (ram_addra),
      .ram_dina  (ram_dina),
      .ram_wea   (ram_wea),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_out   (alu_out)
   );

   fib_seq_ctrl #(
      .LAST_ADDR (5),
      .SEED_CNT  (2)
   ) u_dut_s (
      .clk       (clk),
      .rst       (rst),
      .start     (start_s),
      .busy      (busy_s),
      .done      (done_s),
      .rf_raddr  (rf_raddr_s),
      .rf_rdata  (rf_rdata_s),
      .rf_waddr  (rf_waddr_s),
      .rf_wdata  (rf_wdata_s),
      .rf_we     (rf_we_s),
      .ram_addrb (ram_addrb_s),
      .ram_doutb (ram_doutb_s),
      .ram_addra (ram_addra_s),
      .ram_dina  (ram_dina_s),
      .ram_wea   (ram_wea_s),
      .alu_a     (alu_a_s),
      .alu_b     (alu_b_s),
      .alu_op    (alu_op_s),
      .alu_out   (alu_out_s)
   );

   // ALU model: only the add opcode yields a sum
   assign alu_out   = (alu_op == AluOpAdd) ? alu_a + alu_b : 32'hDEAD_BEEF;
   assign alu_out_s = (alu_op_s == AluOpAdd) ? alu_a_s + alu_b_s : 32'hDEAD_BEEF;

   // Register file: combinational read
   assign rf_rdata   = rf_mem[rf_raddr];
   assign rf_rdata_s = rf_mem_s[rf_raddr_s];

   // Register file writes, RAM writes and registered RAM port B reads
   always @(posedge clk) begin
      if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
      if (rf_we_s) rf_mem_s[rf_waddr_s] <= rf_wdata_s;
      if (ld_en) begin
         ram_mem[ld_addr]   <= ld_data;
         ram_mem_s[ld_addr] <= ld_data;
      end else begin
         if (ram_wea) ram_mem[ram_addra] <= ram_dina;
         if (ram_wea_s) ram_mem_s[ram_addra_s] <= ram_dina_s;
      end
      ram_doutb   <= ram_mem[ram_addrb];
      ram_doutb_s <= ram_mem_s[ram_addrb_s];
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic load_seeds(input logic [DW-1:0] s0, input logic [DW-1:0] s1);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = '0; ld_data = s0;
      @(negedge clk);
      ld_addr = AW'(1); ld_data = s1;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // One job on the default instance; cycle c is the one that starts at edge c-1
   task automatic run_job(input logic [DW-1:0] s0, input logic [DW-1:0] s1, input bit hold,
                          input bit probe, input int abort_at, input int n_cyc);
      logic [DW-1:0]    f [64];
      logic [AW+DW-1:0] e;
      int               n_done;
      bit               aborted;
      bit               exp_busy;
      load_seeds(s0, s1);
      f[0] = s0;
      f[1] = s1;
      exp_q.delete();
      for (int i = 2; i < 64; i++) begin
         f[i] = f[i-2] + f[i-1];
         exp_q.push_back({AW'(i), f[i]});
      end
      start = 1'b1;
      @(posedge clk);
      n_done  = 0;
      aborted = 1'b0;
      for (int c = 1; c <= n_cyc; c++) begin
         @(negedge clk);
         if (!hold) start = (c == 40);
         if (abort_at != 0 && c == abort_at) begin
            #1 rst = 1'b1;
            #1;
            check_eq("rst_outs_zero", outs_nz, 0);
            exp_q.delete();
            aborted = 1'b1;
         end
         if (aborted) begin
            check_eq("abort_rf_we", rf_we, 0);
            check_eq("abort_ram_wea", ram_wea, 0);
            check_eq("abort_busy", busy, 0);
            if (c == abort_at + 3) rst = 1'b0;
         end else begin
            exp_busy = (c <= DONE_CYC) || (hold && c >= DONE_CYC + 2);
            check_eq("busy", busy, exp_busy);
            check_eq("done", done, c == DONE_CYC);
            n_done += int'(done);
            if (c <= 2 * SEEDS) check_eq("load_wea", ram_wea, 0);
            if (ram_wea) begin
               if (exp_q.size() == 0) begin
                  check_eq("extra_write", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check_eq("ram_addra", ram_addra, e[AW+DW-1:DW]);
                  check_eq("ram_dina", ram_dina, e[DW-1:0]);
                  check_eq("rf_we_exec", rf_we, 1);
                  check_eq("rf_waddr_exec", rf_waddr, e[AW+DW-1:DW]);
                  check_eq("rf_wdata_exec", rf_wdata, e[DW-1:0]);
               end
            end
            if (hold && c == DONE_CYC + 2) begin
               check_eq("restart_addrb", ram_addrb, 0);
               check_eq("restart_rf_we", rf_we, 0);
            end
            if (probe) begin
               if (c == 1) check_eq("p1_addrb", ram_addrb, 0);
               if (c == 3) check_eq("p3_addrb", ram_addrb, 1);
               if (c == 2) begin
                  check_eq("p2_rf_we", rf_we, 1);
                  check_eq("p2_rf_waddr", rf_waddr, 0);
                  check_eq("p2_rf_wdata", rf_wdata, s0);
               end
               if (c == 5) check_eq("p5_rf_raddr", rf_raddr, 0);
               if (c == 6) check_eq("p6_rf_raddr", rf_raddr, 1);
               if (c == 7) begin
                  check_eq("p7_we", {rf_we, ram_wea}, 2'b11);
                  check_eq("p7_addr", {rf_waddr, ram_addra}, {AW'(2), AW'(2)});
                  check_eq("p7_data", rf_wdata, 4);
                  check_eq("p7_alu_op", alu_op, 1);
               end
            end
         end
      end
      if (!aborted) begin
         check_eq("one_done", n_done, 1);
         check_eq("sb_empty", exp_q.size(), 0);
      end
      start = 1'b0;
   endtask

   initial begin
      int n_done_s;
      rst     = 1'b1;
      start   = 1'b0;
      start_s = 1'b0;
      ld_en   = 1'b0;
      ld_addr = '0;
      ld_data = '0;
      repeat (3) @(negedge clk);
      check_eq("reset_outs_zero", outs_nz, 0);
      check_eq("reset_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("idle_busy", busy, 0);

      // Seeds 1,1 with a stray start pulse at cycle 40
      run_job(32'd1, 32'd1, 1'b0, 1'b0, 0, DONE_CYC + 3);
      check_eq("r10_fib", rf_mem[10], 89);
      check_eq("ram10_fib", ram_mem[10], 89);
      check_eq("r47_fib", rf_mem[47], 512559680);

      // Seeds 2,2 with the timing probe
      run_job(32'd2, 32'd2, 1'b0, 1'b1, 0, DONE_CYC + 3);
      check_eq("r2_lab", rf_mem[2], 4);
      check_eq("r10_lab", rf_mem[10], 178);
      check_eq("ram0_kept", ram_mem[0], 2);
      check_eq("ram1_kept", ram_mem[1], 2);
      for (int i = 2; i < 64; i++) check_eq("ram_eq_rf", ram_mem[i], rf_mem[i]);

      // start held high: one job, then a second begins after IDLE
      run_job(32'd5, 32'd8, 1'b1, 1'b0, 0, DONE_CYC + 4);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset mid-job, then a clean job afterwards
      run_job(32'd1, 32'd1, 1'b0, 1'b0, 50, 60);
      run_job(32'd7, 32'd3, 1'b0, 1'b0, 0, DONE_CYC + 3);

      // Short instance: LAST_ADDR=5, seeds 3,4
      load_seeds(32'd3, 32'd4);
      start_s = 1'b1;
      @(posedge clk);
      n_done_s = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start_s = 1'b0;
         check_eq("s_done", done_s, c == 17);
         check_eq("s_busy", busy_s, c <= 17);
         n_done_s += int'(done_s);
      end
      check_eq("s_one_done", n_done_s, 1);
      check_eq("s_r2", rf_mem_s[2], 7);
      check_eq("s_r3", rf_mem_s[3], 11);
      check_eq("s_r4", rf_mem_s[4], 18);
      check_eq("s_r5", rf_mem_s[5], 29);
      check_eq("s_ram5", ram_mem_s[5], 29);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
